regwrite_arbiter: RTL

Round-robin arbiter that shares the single write port of the 16 x 16 three-ported register file among NREQ write-back requesters, such as ALU result, memory load and debug/host load. The block grants at most one write per cycle and drives the register file's regwrite/wa/wd from an output register. It also keeps a per-register pending-write scoreboard so the decode stage can stall reads of registers with a write in flight. It sits between the write-back sources and the register file.

---
 rtl/regwrite_arbiter_pkg.sv | 11 +
 rtl/regwrite_arbiter_rr_pick.sv | 37 +++
 rtl/regwrite_arbiter.sv | 99 +++++++++
 3 files changed

// File: rtl/regwrite_arbiter_pkg.sv
// Shared constants for the register-file write-back arbiter.
// Holds the default register-file geometry, the default requester count and
// the index of the hardwired-zero register.
package regwrite_arbiter_pkg;

    localparam int DEF_WIDTH   = 16;  // data width of one register
    localparam int DEF_REGBITS = 4;   // register address width
    localparam int DEF_NREQ    = 3;   // number of write-back requesters
    localparam int ZERO_REG    = 0;   // register that always reads zero

endpackage

// File: rtl/regwrite_arbiter_rr_pick.sv
// Combinational round-robin picker.
// Ports:
//   req     in  N   request vector
//   ptr     in  PW  highest-priority index this cycle (must be < N)
//   gnt     out N   one-hot grant, zero when no request
//   gnt_idx out PW  binary index of the granted requester (0 when none)
//   any     out 1   at least one request present
module rr_pick #(
    parameter int N  = 3,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] gnt_idx,
    output logic          any
);

    // Walk N positions starting at ptr; the first request seen wins.
    always_comb begin
        int idx;
        idx     = 0;
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N) idx = idx - N;
            if (!any && req[idx]) begin
                any      = 1'b1;
                gnt[idx] = 1'b1;
                gnt_idx  = PW'(idx);
            end
        end
    end

endmodule

// File: rtl/regwrite_arbiter.sv
// Round-robin arbiter for the single write port of the register file.
// Grants one write-back requester per cycle, registers the winning write
// towards the file and tracks which registers have a write in flight.
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   req_valid/wa/wd   per-requester write requests (flattened vectors)
//   req_ready         one-hot accept, combinational from req_valid
//   regwrite/wa/wd    registered write towards the register file
//   pend              per-register write-in-flight scoreboard
module regwrite_arbiter
    import regwrite_arbiter_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int REGBITS = DEF_REGBITS,
    parameter int NREQ    = DEF_NREQ
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*REGBITS-1:0] req_wa,
    input  logic [NREQ*WIDTH-1:0]   req_wd,
    output logic [NREQ-1:0]         req_ready,
    output logic                    regwrite,
    output logic [REGBITS-1:0]      wa,
    output logic [WIDTH-1:0]        wd,
    output logic [(1<<REGBITS)-1:0] pend
);

    localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int NREG = 1 << REGBITS;

    logic [PW-1:0]      ptr_q, ptr_d;
    logic               rw_q, rw_d;
    logic [REGBITS-1:0] wa_q, wa_d;
    logic [WIDTH-1:0]   wd_q, wd_d;
    logic [NREG-1:0]    pend_q, pend_d;

    logic [PW-1:0]      gnt_idx;
    logic               any;
    logic [REGBITS-1:0] wa_g;
    logic [WIDTH-1:0]   wd_g;
    logic               wr_nz;

    rr_pick #(.N(NREQ), .PW(PW)) u_pick (
        .req     (req_valid),
        .ptr     (ptr_q),
        .gnt     (req_ready),
        .gnt_idx (gnt_idx),
        .any     (any)
    );

    // The write port is free every cycle, so any grant is a transfer.
    assign wa_g  = req_wa[int'(gnt_idx)*REGBITS +: REGBITS];
    assign wd_g  = req_wd[int'(gnt_idx)*WIDTH +: WIDTH];
    // Writes to the zero register are consumed but never reach the file.
    assign wr_nz = any && (wa_g != REGBITS'(ZERO_REG));

    always_comb begin
        ptr_d = ptr_q;
        rw_d  = wr_nz;
        wa_d  = wa_q;
        wd_d  = wd_q;
        if (any) begin
            ptr_d = (gnt_idx == PW'(NREQ-1)) ? '0 : gnt_idx + 1'b1;
            wa_d  = wa_g;
            wd_d  = wd_g;
        end
    end

    // Clear first, then set: a back-to-back write to the same register
    // keeps its pending bit high through the commit of the older write.
    always_comb begin
        pend_d = pend_q;
        if (rw_q)  pend_d[wa_q] = 1'b0;
        if (wr_nz) pend_d[wa_g] = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q  <= '0;
            rw_q   <= 1'b0;
            wa_q   <= '0;
            wd_q   <= '0;
            pend_q <= '0;
        end else begin
            ptr_q  <= ptr_d;
            rw_q   <= rw_d;
            wa_q   <= wa_d;
            wd_q   <= wd_d;
            pend_q <= pend_d;
        end
    end

    assign regwrite = rw_q;
    assign wa       = wa_q;
    assign wd       = wd_q;
    assign pend     = pend_q;

endmodule
